// File: rtl/booth_mul_seq_if.sv
// Handshake bundle for booth_mul_seq.
//   master : operand producer / result consumer side (drives in_valid, a_in, b_in,
//            flush, out_ready; observes in_ready, out_valid, product, busy)
//   slave  : the multiplier controller
interface booth_mul_seq_if #(
  parameter int WIDTH = 16
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   a_in;
  logic [WIDTH-1:0]   b_in;
  logic               flush;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] product;
  logic               busy;

  modport master (
    output in_valid, a_in, b_in, flush, out_ready,
    input  in_ready, out_valid, product, busy
  );

  modport slave (
    input  in_valid, a_in, b_in, flush, out_ready,
    output in_ready, out_valid, product, busy
  );
endinterface

// File: rtl/booth_mul_seq.sv
// Sequential 16x16 signed radix-4 Booth multiplier.
//   booth_decoder : one radix-4 window -> partial product (xout) plus carry-in (cout)
//                   that completes the two's-complement negation of -x / -2x.
//   booth_mul_seq : steps the decoder over the 8 windows of the multiplier, one per
//                   clock, accumulating shifted partial products.
// Ports (booth_mul_seq):
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    booth_mul_seq_if.slave: in_valid/in_ready/a_in/b_in operand handshake,
//          flush abort, out_valid/out_ready/product result handshake, busy status

module booth_decoder #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] xin,
  input  logic [2:0]       yin,
  output logic [WIDTH:0]   xout,
  output logic             cout
);
  logic [WIDTH:0] x1;
  logic [WIDTH:0] x2;

  assign x1 = {xin[WIDTH-1], xin};
  assign x2 = {xin, 1'b0};

  // Negative multiples are emitted as one's complement; cout supplies the +1.
  always_comb begin
    xout = '0;
    cout = 1'b0;
    unique case (yin)
      3'b001, 3'b010: xout = x1;
      3'b011:         xout = x2;
      3'b100: begin
        xout = ~x2;
        cout = 1'b1;
      end
      3'b101, 3'b110: begin
        xout = ~x1;
        cout = 1'b1;
      end
      default: begin
        xout = '0;
        cout = 1'b0;
      end
    endcase
  end
endmodule

module booth_mul_seq #(
  parameter int WIDTH = 16,
  parameter int STEPS = WIDTH / 2
) (
  input logic            clk,
  input logic            rst_n,
  booth_mul_seq_if.slave bus
);
  localparam int PW = 2 * WIDTH;
  localparam int SW = $clog2(STEPS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic [WIDTH-1:0] x_reg;
  logic [WIDTH:0]   y_reg;
  logic [PW-1:0]    acc;
  logic [SW-1:0]    step;
  logic [PW-1:0]    product_r;
  logic             in_ready_r;
  logic             out_valid_r;
  logic             busy_r;

  logic [WIDTH:0]   xout;
  logic             cout;
  logic [PW-1:0]    pp;
  logic [PW-1:0]    acc_next;
  logic [SW:0]      shamt;

  // y_reg shifts right two bits per step, so the current window is always y_reg[2:0].
  booth_decoder #(.WIDTH(WIDTH)) u_dec (
    .xin  (x_reg),
    .yin  (y_reg[2:0]),
    .xout (xout),
    .cout (cout)
  );

  assign shamt    = {step, 1'b0};
  assign pp       = {{(PW-WIDTH-1){xout[WIDTH]}}, xout};
  assign acc_next = acc + (pp << shamt) + (PW'(cout) << shamt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      x_reg       <= '0;
      y_reg       <= '0;
      acc         <= '0;
      step        <= '0;
      product_r   <= '0;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else if (bus.flush) begin
      // product_r is deliberately left alone so the last result stays visible.
      state       <= IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid && in_ready_r) begin
            state      <= CALC;
            x_reg      <= bus.a_in;
            y_reg      <= {bus.b_in, 1'b0};
            acc        <= '0;
            step       <= '0;
            in_ready_r <= 1'b0;
            busy_r     <= 1'b1;
          end else begin
            in_ready_r <= 1'b1;
          end
        end
        CALC: begin
          acc   <= acc_next;
          step  <= step + 1'b1;
          y_reg <= {2'b00, y_reg[WIDTH:2]};
          if (step == SW'(STEPS - 1)) begin
            state       <= DONE;
            product_r   <= acc_next;
            out_valid_r <= 1'b1;
            busy_r      <= 1'b0;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state       <= IDLE;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.busy      = busy_r;
  assign bus.product   = product_r;
endmodule

// File: tb/tb_booth_mul_seq.sv
// Testbench for booth_mul_seq: directed corner cases, backpressure, flush, async
// reset, then randomized operand pairs checked against a signed integer product.
module tb_booth_mul_seq;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  booth_mul_seq_if bus ();

  booth_mul_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] last_prod = 32'h0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
    int p;
    p = int'($signed(a)) * int'($signed(b));
    return 32'(p);
  endfunction

  // Present operands from a negedge and hold until accepted; returns at the
  // negedge that follows the accepting edge.
  task automatic start_op(input logic [15:0] a, input logic [15:0] b);
    int cnt;
    bus.a_in     = a;
    bus.b_in     = b;
    bus.in_valid = 1'b1;
    cnt = 0;
    while (!bus.in_ready && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    chk("accept_wait", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  // Full transaction: accept, wait for result, hold backpressure bp cycles, drain.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input int bp,
                        input bit early_rdy, input bit detail);
    int          lat;
    logic [31:0] exp;
    exp = ref_mul(a, b);
    bus.out_ready = early_rdy;
    start_op(a, b);
    if (detail) begin
      chk("busy_in_calc", 32'(bus.busy), 32'd1);
      chk("in_ready_in_calc", 32'(bus.in_ready), 32'd0);
    end
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", 32'(lat), 32'd8);
    chk("product", bus.product, exp);
    if (!early_rdy) begin
      for (int i = 0; i < bp; i++) begin
        @(negedge clk);
        chk("bp_product", bus.product, exp);
        chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
        chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
      end
      bus.out_ready = 1'b1;
    end
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("drain_out_valid", 32'(bus.out_valid), 32'd0);
    if (detail) chk("drain_in_ready", 32'(bus.in_ready), 32'd1);
    last_prod = exp;
  endtask

  initial begin
    int seen;
    logic [15:0] ra, rb;
    bus.in_valid  = 1'b0;
    bus.a_in      = '0;
    bus.b_in      = '0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_product", bus.product, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rel_in_ready_low", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    chk("rel_in_ready_high", 32'(bus.in_ready), 32'd1);

    run_op(16'd3, 16'd5, 0, 1'b0, 1'b1);
    chk("dir_3x5", last_prod, 32'h0000000F);
    run_op(16'h8000, 16'h8000, 0, 1'b0, 1'b1);
    chk("dir_min_min", bus.product, 32'h40000000);
    run_op(16'h7FFF, 16'h8000, 0, 1'b0, 1'b1);
    chk("dir_max_min", bus.product, 32'hC0008000);
    run_op(16'hFFFF, 16'hFFFF, 0, 1'b1, 1'b1);
    chk("dir_m1_m1", bus.product, 32'h00000001);
    run_op(16'd0, 16'd1234, 0, 1'b0, 1'b1);
    run_op(16'hFFF9, 16'd9, 0, 1'b0, 1'b1);

    // back-to-back with 5 cycles of backpressure on the first result
    run_op(16'd1234, 16'hFB2E, 5, 1'b0, 1'b1);
    run_op(16'h5A5A, 16'hA5A5, 0, 1'b0, 1'b1);

    // flush coincident with in_valid: operands must not be taken
    bus.a_in = 16'd7;
    bus.b_in = 16'd7;
    bus.in_valid = 1'b1;
    bus.flush = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.flush = 1'b0;
    chk("flush_accept_busy", 32'(bus.busy), 32'd0);
    chk("flush_accept_in_ready", 32'(bus.in_ready), 32'd1);

    // flush while the step-3 window is about to be processed
    start_op(16'd1111, 16'd2222);
    repeat (3) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    chk("flush_busy", 32'(bus.busy), 32'd0);
    chk("flush_out_valid", 32'(bus.out_valid), 32'd0);
    chk("flush_in_ready", 32'(bus.in_ready), 32'd1);
    chk("flush_product_kept", bus.product, last_prod);
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    chk("flush_no_out_valid", 32'(seen), 32'd0);
    run_op(16'hFF00, 16'd300, 0, 1'b0, 1'b1);

    // async reset mid-calculation
    start_op(16'd4321, 16'hC000);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(bus.busy), 32'd0);
    chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("arst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("arst_product", bus.product, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    chk("arst_no_out_valid", 32'(seen), 32'd0);
    run_op(16'h8001, 16'h7FFF, 0, 1'b0, 1'b1);

    // randomized pairs with random idle gaps and random consumer readiness
    for (int k = 0; k < 2000; k++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (k % 8 == 0) ra = 16'h8000;
      if (k % 11 == 0) rb = 16'h8000;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_op(ra, rb, $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
